// File: rtl/axi_pkg.sv
// Shared AXI4 constants, channel widths and the CPU-side master FSM state type.
// Width macros match the codebase AXI_define.svh and are guarded so that header may come first.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

    typedef enum logic [2:0] {
        MS_IDLE,
        MS_AR,
        MS_R,
        MS_AW,
        MS_W,
        MS_B
    } master_state_e;

endpackage

// File: rtl/axi_master_cpu.sv
// Single-outstanding AXI4 initiator: turns one CPU load/store request into a
// single-beat AXI transaction and returns a one-cycle completion pulse.
module axi_master_cpu
    import axi_pkg::*;
#(
    parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0,
    parameter bit                      CHECK_ID  = 1'b1
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    // CPU request / completion port
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [31:0]                 req_addr,
    input  logic [31:0]                 req_wdata,
    input  logic [3:0]                  req_wstrb,
    output logic                        resp_valid,
    output logic [31:0]                 resp_rdata,
    output logic                        resp_err,
    // write address channel
    output logic [`AXI_ID_BITS-1:0]     AWID,
    output logic [31:0]                 AWADDR,
    output logic [`AXI_LEN_BITS-1:0]    AWLEN,
    output logic [`AXI_SIZE_BITS-1:0]   AWSIZE,
    output logic [1:0]                  AWBURST,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    // write data channel
    output logic [31:0]                 WDATA,
    output logic [3:0]                  WSTRB,
    output logic                        WLAST,
    output logic                        WVALID,
    input  logic                        WREADY,
    // write response channel
    input  logic [`AXI_IDS_BITS-1:0]    BID,
    input  logic [1:0]                  BRESP,
    input  logic                        BVALID,
    output logic                        BREADY,
    // read address channel
    output logic [`AXI_ID_BITS-1:0]     ARID,
    output logic [31:0]                 ARADDR,
    output logic [`AXI_LEN_BITS-1:0]    ARLEN,
    output logic [`AXI_SIZE_BITS-1:0]   ARSIZE,
    output logic [1:0]                  ARBURST,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    // read data channel
    input  logic [`AXI_IDS_BITS-1:0]    RID,
    input  logic [31:0]                 RDATA,
    input  logic [1:0]                  RRESP,
    input  logic                        RLAST,
    input  logic                        RVALID,
    output logic                        RREADY
);

    master_state_e state_q, state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        r_done;
    logic        b_done;

    // Slaves widen the ID; only the low bits carry this master's identity.
    function automatic logic resp_bad(input logic [1:0]               resp,
                                      input logic [`AXI_IDS_BITS-1:0] id);
        return (resp != AXI_RESP_OKAY) ||
               (CHECK_ID && (id[`AXI_ID_BITS-1:0] != MASTER_ID));
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= MS_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: the request latches are plain registers, not a memory array, so
    // they take the asynchronous reset like any other flop.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (state_q == MS_IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        WLAST     = 1'b0;
        WDATA     = '0;
        WSTRB     = '0;
        BREADY    = 1'b0;
        unique case (state_q)
            MS_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_write ? MS_AW : MS_AR;
            end
            MS_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_d = MS_R;
            end
            MS_R: begin
                RREADY = 1'b1;
                if (RVALID) state_d = MS_IDLE;
            end
            MS_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) state_d = MS_W;
            end
            MS_W: begin
                WVALID = 1'b1;
                WLAST  = 1'b1;
                WDATA  = wdata_q;
                WSTRB  = wstrb_q;
                if (WREADY) state_d = MS_B;
            end
            MS_B: begin
                BREADY = 1'b1;
                if (BVALID) state_d = MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    assign r_done = (state_q == MS_R) && RVALID;
    assign b_done = (state_q == MS_B) && BVALID;

    // Completion is registered so resp_valid lines up with the return to IDLE.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= r_done || b_done;
            resp_err   <= r_done ? resp_bad(RRESP, RID) :
                          b_done ? resp_bad(BRESP, BID) : 1'b0;
            if (r_done) resp_rdata <= RDATA;
        end
    end

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = '0;
    assign AWSIZE  = AXI_SIZE_WORD;
    assign AWBURST = AXI_BURST_INCR;
    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = '0;
    assign ARSIZE  = AXI_SIZE_WORD;
    assign ARBURST = AXI_BURST_INCR;

    // Single-beat bursts make RLAST redundant; upper ID bits belong to the interconnect.
    logic unused_ok;
    assign unused_ok = &{1'b0, RLAST, BID[`AXI_IDS_BITS-1:`AXI_ID_BITS],
                         RID[`AXI_IDS_BITS-1:`AXI_ID_BITS]};

endmodule

// File: tb/tb_axi_master_cpu.sv
// Directed bench for axi_master_cpu: a timeline model of each transaction
// predicts every channel signal cycle by cycle; a scripted slave answers on that timeline.
`timescale 1ns/1ps
module tb_axi_master_cpu;
    import axi_pkg::*;

    localparam logic [3:0] MID = 4'd1;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  AWID, ARID, AWLEN, ARLEN;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [3:0]  WSTRB;
    logic [7:0]  BID, RID;

    always #5 ACLK = ~ACLK;

    axi_master_cpu #(.MASTER_ID(MID), .CHECK_ID(1'b1)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    // d0/d1/d2: wait cycles before the slave accepts AW|AR, W|R, B
    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          d0, d1, d2;
        logic [1:0]  resp;
        logic [7:0]  id;
        logic [31:0] rdata;
        int          acc;
    } txn_t;

    txn_t pend_q[$];
    txn_t cur;
    bit   cur_active;
    int   cyc, checks, failures;
    int   last_acc, prev_acc, last_resp_cyc, aw_cycles;
    logic last_err;
    logic [31:0] last_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int d0, input int d1, input int d2,
                        input logic [1:0] resp, input logic [7:0] id, input logic [31:0] rdata);
        txn_t t;
        t.write = wr; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
        t.d0 = d0; t.d1 = d1; t.d2 = d2; t.resp = resp; t.id = id; t.rdata = rdata; t.acc = 0;
        pend_q.push_back(t);
    endtask

    // Compare this cycle's outputs with the timeline, then play slave and CPU for it.
    task automatic compare_and_drive();
        bit ex_ar, ex_r, ex_aw, ex_w, ex_b, ex_rv, ex_err, ex_ready;
        int s, done, e0, e1, e2;
        ex_ar = 0; ex_r = 0; ex_aw = 0; ex_w = 0; ex_b = 0; ex_rv = 0; ex_err = 0;
        ex_ready = 1; done = -1; e0 = -1; e1 = -1; e2 = -1;
        if (cur_active) begin
            s  = cur.acc + 1;
            e0 = s + cur.d0;
            e1 = e0 + 1 + cur.d1;
            if (cur.write) begin
                e2    = e1 + 1 + cur.d2;
                done  = e2 + 1;
                ex_aw = (cyc >= s) && (cyc <= e0);
                ex_w  = (cyc > e0) && (cyc <= e1);
                ex_b  = (cyc > e1) && (cyc <= e2);
            end else begin
                done  = e1 + 1;
                ex_ar = (cyc >= s) && (cyc <= e0);
                ex_r  = (cyc > e0) && (cyc <= e1);
            end
            ex_rv    = (cyc == done);
            ex_ready = ex_rv;
            ex_err   = (cur.resp != AXI_RESP_OKAY) || (cur.id[3:0] != MID);
        end

        check("req_ready", req_ready, ex_ready);
        check("resp_valid", resp_valid, ex_rv);
        check("ARVALID", ARVALID, ex_ar);
        check("RREADY", RREADY, ex_r);
        check("AWVALID", AWVALID, ex_aw);
        check("WVALID", WVALID, ex_w);
        check("WLAST", WLAST, ex_w);
        check("BREADY", BREADY, ex_b);
        if (ex_ar) begin
            check("ARADDR", ARADDR, cur.addr);
            check("ARID", ARID, MID);
            check("ARLEN", ARLEN, 0);
            check("ARSIZE", ARSIZE, 2);
            check("ARBURST", ARBURST, 1);
        end
        if (ex_aw) begin
            check("AWADDR", AWADDR, cur.addr);
            check("AWID", AWID, MID);
            check("AWLEN", AWLEN, 0);
            check("AWSIZE", AWSIZE, 2);
            check("AWBURST", AWBURST, 1);
        end
        if (ex_w) begin
            check("WDATA", WDATA, cur.wdata);
            check("WSTRB", WSTRB, cur.wstrb);
        end
        if (ex_rv) begin
            check("resp_err", resp_err, ex_err);
            if (!cur.write && !ex_err) check("resp_rdata", resp_rdata, cur.rdata);
        end

        if (resp_valid) begin
            last_resp_cyc = cyc;
            last_err      = resp_err;
            last_rdata    = resp_rdata;
        end
        if (AWVALID) aw_cycles++;

        ARREADY = ex_ar && (cyc == e0);
        AWREADY = ex_aw && (cyc == e0);
        WREADY  = ex_w && (cyc == e1);
        RVALID  = ex_r && (cyc == e1);
        RDATA   = RVALID ? cur.rdata : 32'h0;
        RRESP   = RVALID ? cur.resp : 2'b00;
        RID     = RVALID ? cur.id : 8'h00;
        RLAST   = RVALID;
        BVALID  = ex_b && (cyc == e2);
        BRESP   = BVALID ? cur.resp : 2'b00;
        BID     = BVALID ? cur.id : 8'h00;

        if (cur_active && cyc == done) cur_active = 0;
        if (pend_q.size() > 0) begin
            req_valid = 1'b1;
            req_write = pend_q[0].write;
            req_addr  = pend_q[0].addr;
            req_wdata = pend_q[0].wdata;
            req_wstrb = pend_q[0].wstrb;
            if (!cur_active) begin
                cur        = pend_q.pop_front();
                cur.acc    = cyc;
                cur_active = 1;
                prev_acc   = last_acc;
                last_acc   = cyc;
            end
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        cyc++;
        @(negedge ACLK);
        if (ARESETn) compare_and_drive();
    endtask

    task automatic run_idle(input string name);
        int n;
        n = 0;
        while ((pend_q.size() > 0 || cur_active) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check({name, "_timeout"}, 1, 0);
        repeat (2) step();
    endtask

    task automatic clear_slave();
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; BRESP = 0; BID = 0;
        RVALID = 0; RDATA = 0; RRESP = 0; RID = 0; RLAST = 0;
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; cyc = 0; cur_active = 0;
        last_acc = 0; prev_acc = 0; last_resp_cyc = 0; aw_cycles = 0;
        last_err = 0; last_rdata = 0;
        clear_slave();
        ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_valids", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 0);
        check("rst_addr", ARADDR, 0);
        ARESETn = 1'b1;
        repeat (2) step();

        // zero-wait read
        push(0, 32'h0000_0040, 0, 0, 0, 0, 0, 2'b00, 8'h01, 32'hDEAD_BEEF);
        run_idle("read0");
        check("pin_read_latency", last_resp_cyc - last_acc, 3);
        check("pin_read_data", last_rdata, 32'hDEAD_BEEF);
        check("pin_read_err", last_err, 0);

        // write with AW and W backpressure
        aw_cycles = 0;
        push(1, 32'h0000_1000, 32'h1234_5678, 4'b0011, 3, 2, 0, 2'b00, 8'h01, 0);
        run_idle("write_bp");
        check("pin_aw_held", aw_cycles, 4);
        check("pin_write_latency", last_resp_cyc - last_acc, 9);
        check("pin_write_err", last_err, 0);

        // error response then a clean read
        push(0, 32'h0000_0080, 0, 0, 1, 2, 0, AXI_RESP_DECERR, 8'h01, 32'hBAD0_BAD0);
        run_idle("read_err");
        check("pin_decerr", last_err, 1);
        push(0, 32'h0000_0084, 0, 0, 0, 0, 0, 2'b00, 8'h01, 32'hCAFE_F00D);
        run_idle("read_ok");
        check("pin_after_err", last_err, 0);
        check("pin_after_err_data", last_rdata, 32'hCAFE_F00D);

        // ID mismatch, then an ID differing only in the widened upper bits
        push(1, 32'h0000_2000, 32'hA5A5_5A5A, 4'b1111, 0, 0, 1, 2'b00, 8'h02, 0);
        run_idle("id_bad");
        check("pin_id_mismatch", last_err, 1);
        push(1, 32'h0000_2004, 32'h0F0F_F0F0, 4'b1000, 0, 0, 0, 2'b00, 8'h11, 0);
        run_idle("id_upper");
        check("pin_id_upper_ignored", last_err, 0);

        // back-to-back: write waits behind the read and is taken in its resp cycle
        push(0, 32'h0000_3000, 0, 0, 0, 0, 0, 2'b00, 8'h01, 32'h0BAD_F00D);
        push(1, 32'h0000_3004, 32'h7777_8888, 4'b0101, 0, 0, 0, 2'b00, 8'h01, 0);
        run_idle("b2b");
        check("pin_b2b_gap", last_acc - prev_acc, 3);

        // reset while WVALID is up
        push(1, 32'h0000_4000, 32'h1111_2222, 4'b1111, 0, 5, 0, 2'b00, 8'h01, 0);
        n = 0;
        while (!(cur_active && cur.write && cyc == cur.acc + 3) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("reset_setup_timeout", 1, 0);
        check("pre_reset_wvalid", WVALID, 1);
        #3 ARESETn = 1'b0;
        #1;
        check("async_rst_wvalid", WVALID, 0);
        check("async_rst_req_ready", req_ready, 1);
        check("async_rst_resp_valid", resp_valid, 0);
        pend_q.delete();
        cur_active = 0;
        clear_slave();
        repeat (2) step();
        ARESETn = 1'b1;
        repeat (4) step();

        // still functional after reset
        push(0, 32'h0000_5000, 0, 0, 0, 0, 0, 2'b00, 8'h01, 32'h5555_AAAA);
        run_idle("post_reset");
        check("pin_post_reset_data", last_rdata, 32'h5555_AAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
